// File: rtl/sram_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_controller_pkg
//  Purpose  : Shared types and default constants for the 16-bit SRAM
//             data-memory back end (FSM state encoding, parameter defaults).
//  Revision : 1.0  initial release
// ============================================================================
package sram_controller_pkg;

    // Access sequencer states; encodings are fixed so they can be observed
    // on a debug bus and matched by external tooling.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned c_DEFAULT_ADDR_BASE   = 1024;
    localparam int unsigned c_DEFAULT_SRAM_AW     = 18;
    localparam int unsigned c_DEFAULT_WAIT_CYCLES = 5;

endpackage
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sram_controller
//  Purpose  : MEM-stage data memory back end for an off-chip 16-bit SRAM.
//             Each 32-bit load/store is split into two halfword accesses
//             (low half, then high half) of WAIT_CYCLES cycles each. ready
//             drops while a request is outstanding and rises for the single
//             DONE cycle.
//  Ports    : clk, rst (async, active high)
//             wr_en/rd_en/address/write_data  - request from the pipeline
//             read_data (registered), ready   - response to the pipeline
//             sram_addr/sram_dq_out/sram_dq_oe/sram_we_n/sram_dq_in - SRAM
//  Revision : 1.0  initial release
// ============================================================================
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = c_DEFAULT_ADDR_BASE,
    parameter int unsigned SRAM_AW     = c_DEFAULT_SRAM_AW,
    parameter int unsigned WAIT_CYCLES = c_DEFAULT_WAIT_CYCLES   // >= 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned          c_CNT_W    = $clog2(WAIT_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(WAIT_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 r_op_write;
    logic                 w_op_write_next;
    logic [SRAM_AW-2:0]   r_word;
    logic [SRAM_AW-2:0]   w_word_next;
    logic [31:0]          r_wdata;
    logic [31:0]          w_wdata_next;
    logic [31:0]          r_read_data;
    logic [31:0]          w_read_data_next;

    // SRAM pins are registered so the strobe and bus enable are glitch-free
    // off chip. Their next values are decoded from the next state, which
    // keeps them aligned with the state they belong to.
    logic [SRAM_AW-1:0]   r_sram_addr;
    logic [SRAM_AW-1:0]   w_sram_addr_next;
    logic [15:0]          r_sram_dq_out;
    logic [15:0]          w_sram_dq_out_next;
    logic                 r_sram_dq_oe;
    logic                 w_sram_dq_oe_next;
    logic                 r_sram_we_n;
    logic                 w_sram_we_n_next;

    logic                 w_req;
    logic                 w_cnt_last;
    logic                 w_active_next;
    logic [SRAM_AW-2:0]   w_req_word;

    assign w_req      = rd_en | wr_en;
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    // Halfword-pair index of the requested 32-bit word. Truncation to the
    // SRAM width is intentional: out-of-range addresses wrap silently.
    assign w_req_word = (SRAM_AW-1)'((address - 32'(ADDR_BASE)) >> 2);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_op_write    <= 1'b0;
            r_word        <= '0;
            r_wdata       <= '0;
            r_read_data   <= '0;
            r_sram_addr   <= '0;
            r_sram_dq_out <= '0;
            r_sram_dq_oe  <= 1'b0;
            r_sram_we_n   <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_op_write    <= w_op_write_next;
            r_word        <= w_word_next;
            r_wdata       <= w_wdata_next;
            r_read_data   <= w_read_data_next;
            r_sram_addr   <= w_sram_addr_next;
            r_sram_dq_out <= w_sram_dq_out_next;
            r_sram_dq_oe  <= w_sram_dq_oe_next;
            r_sram_we_n   <= w_sram_we_n_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, request latch and SRAM pin decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_op_write_next = r_op_write;
        w_word_next     = r_word;
        w_wdata_next    = r_wdata;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    // Write wins when both enables are asserted.
                    w_state_next    = S_LOW;
                    w_cnt_next      = '0;
                    w_op_write_next = wr_en;
                    w_word_next     = w_req_word;
                    w_wdata_next    = write_data;
                end
            end
            S_LOW: begin
                if (w_cnt_last) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (w_cnt_last) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                // A held request is only re-accepted after passing IDLE.
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        w_active_next = (w_state_next == S_LOW) || (w_state_next == S_HIGH);

        w_sram_addr_next   = r_sram_addr;
        w_sram_dq_out_next = r_sram_dq_out;
        if (w_state_next == S_LOW) begin
            w_sram_addr_next = {w_word_next, 1'b0};
            if (w_op_write_next) begin
                w_sram_dq_out_next = w_wdata_next[15:0];
            end
        end else if (w_state_next == S_HIGH) begin
            w_sram_addr_next = {w_word_next, 1'b1};
            if (w_op_write_next) begin
                w_sram_dq_out_next = w_wdata_next[31:16];
            end
        end

        w_sram_dq_oe_next = w_op_write_next & w_active_next;
        // Strobe released on the last cycle of each phase so address and
        // data are held stable across the rising edge of we_n.
        w_sram_we_n_next  = ~(w_op_write_next & w_active_next &
                              (w_cnt_next != c_CNT_LAST));

        // Read capture at the end of the last cycle of each phase, when the
        // SRAM data has had the full wait time to settle.
        w_read_data_next = r_read_data;
        if (!r_op_write && w_cnt_last) begin
            if (r_state == S_LOW) begin
                w_read_data_next[15:0]  = sram_dq_in;
            end else if (r_state == S_HIGH) begin
                w_read_data_next[31:16] = sram_dq_in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready       = ~w_req | (r_state == S_DONE);
    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_sram_dq_out;
    assign sram_dq_oe  = r_sram_dq_oe;
    assign sram_we_n   = r_sram_we_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_controller
//  Purpose  : Self-checking bench for sram_controller with a behavioural
//             16-bit SRAM model, a vector table and an expectation queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    // ---------------- behavioural SRAM (256 halfwords, aliased) -------------
    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    logic [15:0] mem [0:255] = '{default: 16'h0000};
    wr_t         wlog [$];

    assign sram_dq_in = mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (!rst && !sram_we_n && sram_dq_oe) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
            wlog.push_back('{a: sram_addr, d: sram_dq_out});
        end
    end

    // ---------------- checking infrastructure -------------------------------
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        is_read;
        logic [17:0] lo;
        logic [31:0] data;
    } exp_t;
    exp_t        sb [$];
    logic [31:0] last_read;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] lo_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return {off[18:2], 1'b0};
    endfunction

    task automatic push_exp(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        e.is_read = r & ~w;
        e.lo      = lo_of(a);
        e.data    = w ? d : exp;
        sb.push_back(e);
    endtask

    // Drives a request at a falling edge; leaves time at negedge+1.
    task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en      = w;
        rd_en      = r;
        address    = a;
        write_data = d;
        #1;
    endtask

    // Called at negedge+1 of the first stalled cycle; returns in DONE.
    task automatic wait_done(output int stalls);
        stalls = 0;
        while (!ready && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= 100) begin
            check("ready_timeout", 32'(stalls), 32'd11);
        end
    endtask

    task automatic complete(input string tag, input int stalls);
        exp_t e;
        check({tag, "_stalls"}, 32'(stalls), 32'd11);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (e.is_read) begin
            check({tag, "_rdata"}, read_data, e.data);
            last_read = e.data;
        end else begin
            check({tag, "_mem_lo"}, 32'(mem[e.lo[7:0]]), 32'(e.data[15:0]));
            check({tag, "_mem_hi"}, 32'(mem[e.lo[7:0] + 8'd1]), 32'(e.data[31:16]));
            check({tag, "_nstrobe"}, 32'(wlog.size()), 32'd8);
            if (wlog.size() == 8) begin
                check({tag, "_first_addr"}, 32'(wlog[0].a), 32'(e.lo));
                check({tag, "_first_data"}, 32'(wlog[0].d), 32'(e.data[15:0]));
                check({tag, "_last_addr"},  32'(wlog[7].a), 32'(e.lo | 18'd1));
                check({tag, "_last_data"},  32'(wlog[7].d), 32'(e.data[31:16]));
            end
            check({tag, "_rdata_hold"}, read_data, last_read);
        end
    endtask

    // ---------------- global watchdog ----------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ------------------------------------------
    initial begin
        int st;

        vecs[0] = '{1'b1, 1'b0, 32'd1024,              32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'd1024,              32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'd1028,              32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'd1028,              32'h0,        32'h12345678};
        vecs[4] = '{1'b0, 1'b1, 32'd1024,              32'h0,        32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b1, 32'd1032,              32'hCAFEF00D, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'd1032,              32'h0,        32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 32'd1024 + (32'd1 << 19), 32'hA5A55A5A, 32'h0};
        vecs[8] = '{1'b0, 1'b1, 32'd1024,              32'h0,        32'hA5A55A5A};
        vecs[9] = '{1'b0, 1'b1, 32'd1028,              32'h0,        32'h12345678};

        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = '0;
        write_data = '0;
        last_read  = '0;

        repeat (3) @(negedge clk);
        check("rst_read_data", read_data, 32'h0);
        check("rst_sram_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_out", 32'(sram_dq_out), 32'h0);
        check("rst_oe_we_ready", {29'd0, sram_dq_oe, sram_we_n, ready}, 32'b011);
        rst = 1'b0;

        // Idle: no strobes, no bus drive, ready high every cycle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready_we_oe", {29'd0, ready, sram_we_n, sram_dq_oe}, 32'b110);
        end

        // Table-driven accesses.
        for (int i = 0; i < 10; i++) begin
            wlog.delete();
            push_exp(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].exp);
            issue(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
            wait_done(st);
            complete($sformatf("vec%0d", i), st);
            wr_en = 1'b0;
            rd_en = 1'b0;
        end

        // Back-to-back: request held through DONE, both enables set.
        wlog.delete();
        push_exp(1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 32'h0);
        issue(1'b1, 1'b1, 32'd1036, 32'h0BADF00D);
        wait_done(st);
        complete("b2b_first", st);
        @(negedge clk);
        #1;
        check("b2b_gap_ready", 32'(ready), 32'd0);
        check("b2b_gap_we_oe", {30'd0, sram_we_n, sram_dq_oe}, 32'b10);
        wlog.delete();
        push_exp(1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 32'h0);
        wait_done(st);
        complete("b2b_second", st);
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Reset during the HIGH phase of a store.
        issue(1'b1, 1'b0, 32'd1040, 32'hFFFF0000);
        repeat (7) @(negedge clk);
        #1;
        check("mid_high_addr", 32'(sram_addr), 32'(lo_of(32'd1040) | 18'd1));
        check("mid_high_we_oe", {30'd0, sram_we_n, sram_dq_oe}, 32'b01);
        rst = 1'b1;
        #1;
        check("rst_async_we_oe", {30'd0, sram_we_n, sram_dq_oe}, 32'b10);
        check("rst_async_rdata", read_data, 32'h0);
        wr_en     = 1'b0;
        last_read = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        #1;
        check("post_rst_idle", {29'd0, ready, sram_we_n, sram_dq_oe}, 32'b110);

        // FSM must accept a fresh request from IDLE after the reset.
        wlog.delete();
        push_exp(1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678);
        issue(1'b0, 1'b1, 32'd1028, 32'h0);
        wait_done(st);
        complete("post_rst_load", st);
        rd_en = 1'b0;

        check("sb_drained", 32'(sb.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
